// File: rtl/clock_select_controller.sv
`default_nettype none
// =============================================================================
// clock_select_controller : break-before-make sequencer for NUM_CLKS clock-switch slices
// Rev 1.0
// =============================================================================
module clock_select_controller #(
  parameter int NUM_CLKS       = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int RESET_SEL      = 0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  input  logic [2:0]          req_sel_i,
  output logic                req_ready_o,
  output logic [NUM_CLKS-1:0] select_req_o,
  input  logic [NUM_CLKS-1:0] select_ack_i,
  output logic [2:0]          cur_sel_o,
  output logic                done_o,
  output logic                err_o,
  output logic                timeout_flag_o
);

  localparam int                  CNT_W        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]    TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]          RESET_IDX    = 3'(RESET_SEL);
  localparam logic [NUM_CLKS-1:0] RESET_HOT    = NUM_CLKS'(1) << RESET_SEL;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DROP   = 2'd1,
    S_RAISE  = 2'd2,
    S_FINISH = 2'd3
  } state_e;

  function automatic logic [NUM_CLKS-1:0] onehot(input logic [2:0] idx);
    onehot = '0;
    for (int i = 0; i < NUM_CLKS; i++) begin
      if (idx == 3'(i)) onehot[i] = 1'b1;
    end
  endfunction

  logic [NUM_CLKS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CLKS-1:0] ack_s;

  state_e              state_q, state_d;
  logic [NUM_CLKS-1:0] sel_req_q, sel_req_d;
  logic [2:0]          cur_sel_q, cur_sel_d;
  logic [2:0]          target_q, target_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                tflag_q, tflag_d;

  logic                accept;
  logic                out_of_range;
  logic                wait_expired;
  logic [NUM_CLKS-1:0] target_hot;

  // Acknowledges come from the switched clock domains; resample before use.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= select_ack_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign ack_s        = sync_q[SYNC_STAGES-1];
  assign req_ready_o  = (state_q == S_IDLE);
  assign accept       = req_valid_i && req_ready_o;
  assign out_of_range = ({1'b0, req_sel_i} >= 4'(NUM_CLKS));
  assign wait_expired = (cnt_q == TIMEOUT_LAST);
  assign target_hot   = onehot(target_q);

  always_comb begin
    state_d   = state_q;
    sel_req_d = sel_req_q;
    cur_sel_d = cur_sel_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    tflag_d   = tflag_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (out_of_range) begin
            err_d = 1'b1;
          end else if (req_sel_i == cur_sel_q) begin
            done_d = 1'b1;
          end else begin
            target_d  = req_sel_i;
            sel_req_d = '0;
            tflag_d   = 1'b0;
            cnt_d     = '0;
            state_d   = S_DROP;
          end
        end
      end

      // Completion is tested before the timeout so a late ack still wins.
      S_DROP: begin
        if (ack_s == '0) begin
          sel_req_d = target_hot;
          cnt_d     = '0;
          state_d   = S_RAISE;
        end else if (wait_expired) begin
          err_d   = 1'b1;
          tflag_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RAISE: begin
        if (ack_s == target_hot) begin
          cur_sel_d = target_q;
          done_d    = 1'b1;
          state_d   = S_FINISH;
        end else if (wait_expired) begin
          err_d   = 1'b1;
          tflag_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      sel_req_q <= RESET_HOT;
      cur_sel_q <= RESET_IDX;
      target_q  <= RESET_IDX;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      tflag_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_req_q <= sel_req_d;
      cur_sel_q <= cur_sel_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      tflag_q   <= tflag_d;
    end
  end

  assign select_req_o   = sel_req_q;
  assign cur_sel_o      = cur_sel_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign timeout_flag_o = tflag_q;

`ifndef SYNTHESIS
  a_select_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(select_req_o));
  a_done_err_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(done_o && err_o));
  a_select_gap: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((select_req_o != '0) && ($past(select_req_o) != '0)) |-> (select_req_o == $past(select_req_o)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_clock_select_controller.sv
`default_nettype none
// Testbench for clock_select_controller: table of requests plus hand-written
// timeout, busy and reset-during-switch sequences against a delayed-ack slice model.
module tb_clock_select_controller;

  localparam int N     = 4;
  localparam int BOUND = 200;

  logic         clk       = 1'b0;
  logic         sclk      = 1'b0;
  logic         rst_n     = 1'b0;
  logic         req_valid = 1'b0;
  logic [2:0]   req_sel   = 3'd0;
  logic         req_ready;
  logic [N-1:0] select_req;
  logic [N-1:0] select_ack;
  logic [2:0]   cur_sel;
  logic         done;
  logic         err;
  logic         tflag;

  clock_select_controller #(
    .NUM_CLKS      (N),
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(15),
    .RESET_SEL     (0)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_valid_i   (req_valid),
    .req_sel_i     (req_sel),
    .req_ready_o   (req_ready),
    .select_req_o  (select_req),
    .select_ack_i  (select_ack),
    .cur_sel_o     (cur_sel),
    .done_o        (done),
    .err_o         (err),
    .timeout_flag_o(tflag)
  );

  always #5 clk  = ~clk;
  always #4 sclk = ~sclk;

  // Slice model: each ack follows its select bit after 3 slice-clock edges.
  logic [N-1:0][2:0] sh    = '0;
  logic [N-1:0]      stuck = '0;
  always @(posedge sclk) begin
    for (int i = 0; i < N; i++) sh[i] <= {sh[i][1:0], select_req[i]};
  end
  always_comb begin
    select_ack = '0;
    for (int i = 0; i < N; i++) select_ack[i] = sh[i][2] & ~stuck[i];
  end

  // Protocol monitor: one-hot, zero gap between different bits, DONE/ERR exclusive.
  int           viol = 0;
  logic [N-1:0] prev_sr = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_sr <= select_req;
    end else begin
      viol <= viol + ($onehot0(select_req) ? 0 : 1) + ((done && err) ? 1 : 0)
                   + (((prev_sr != '0) && (select_req != '0) && (prev_sr != select_req)) ? 1 : 0);
      prev_sr <= select_req;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_req(input logic [2:0] sel, output logic [1:0] outcome, output int lat,
                        output logic tflag_first, output logic [N-1:0] sr_first);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_sel   = sel;
    n = 0;
    while (!req_ready && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid   = 1'b0;
    lat         = 1;
    tflag_first = tflag;
    sr_first    = select_req;
    while (!(done || err) && lat < BOUND) begin
      @(negedge clk);
      lat++;
    end
    outcome = {done, err};
  endtask

  typedef struct {
    logic [2:0]   sel;
    logic         exp_err;
    logic         imm;
    logic [2:0]   cur;
    logic [N-1:0] sreq;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]   outcome;
    int           lat;
    logic         tf1;
    logic [N-1:0] sr1;
    int           n;
    int           n_raise;
    logic         ready_seen;
    logic         pulse;

    vecs[0] = '{3'd2, 1'b0, 1'b0, 3'd2, 4'b0100};
    vecs[1] = '{3'd2, 1'b0, 1'b1, 3'd2, 4'b0100};
    vecs[2] = '{3'd5, 1'b1, 1'b1, 3'd2, 4'b0100};
    vecs[3] = '{3'd1, 1'b0, 1'b0, 3'd1, 4'b0010};
    vecs[4] = '{3'd4, 1'b1, 1'b1, 3'd1, 4'b0010};
    vecs[5] = '{3'd3, 1'b0, 1'b0, 3'd3, 4'b1000};
    vecs[6] = '{3'd7, 1'b1, 1'b1, 3'd3, 4'b1000};
    vecs[7] = '{3'd0, 1'b0, 1'b0, 3'd0, 4'b0001};
    vecs[8] = '{3'd0, 1'b0, 1'b1, 3'd0, 4'b0001};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_sreq",  32'(select_req), 32'h1);
    chk("rst_cur",   32'(cur_sel),    32'h0);
    chk("rst_ready", 32'(req_ready),  32'h1);
    chk("rst_done",  32'(done),       32'h0);
    chk("rst_err",   32'(err),        32'h0);
    chk("rst_tflag", 32'(tflag),      32'h0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      do_req(vecs[i].sel, outcome, lat, tf1, sr1);
      chk($sformatf("v%0d_outcome", i), 32'(outcome), vecs[i].exp_err ? 32'h1 : 32'h2);
      chk($sformatf("v%0d_sreq_next", i), 32'(sr1), vecs[i].imm ? 32'(vecs[i].sreq) : 32'h0);
      if (vecs[i].imm) chk($sformatf("v%0d_latency", i), 32'(lat), 32'd1);
      @(negedge clk);
      chk($sformatf("v%0d_pulse_end", i), 32'({done, err}), 32'h0);
      chk($sformatf("v%0d_cur", i),   32'(cur_sel),    32'(vecs[i].cur));
      chk($sformatf("v%0d_sreq", i),  32'(select_req), 32'(vecs[i].sreq));
      chk($sformatf("v%0d_tflag", i), 32'(tflag),      32'h0);
      repeat (4) @(negedge clk);
    end

    // Raise timeout: slice 3 never acknowledges
    stuck = 4'b1000;
    @(negedge clk);
    req_valid = 1'b1;
    req_sel   = 3'd3;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n_raise = 0;
    n = 0;
    while (!(err || done) && n < BOUND) begin
      if (select_req == 4'b1000) n_raise++;
      @(negedge clk);
      n++;
    end
    chk("to_outcome",     32'({done, err}), 32'h1);
    chk("to_raise_cycles", 32'(n_raise),    32'd15);
    chk("to_tflag",       32'(tflag),       32'h1);
    chk("to_cur",         32'(cur_sel),     32'h0);
    chk("to_sreq_held",   32'(select_req),  32'h8);
    @(negedge clk);
    chk("to_tflag_sticky", 32'(tflag), 32'h1);
    chk("to_err_single",   32'(err),   32'h0);
    stuck = '0;
    repeat (4) @(negedge clk);
    do_req(3'd1, outcome, lat, tf1, sr1);
    chk("to_tflag_cleared", 32'(tf1),     32'h0);
    chk("to_next_outcome",  32'(outcome), 32'h2);
    chk("to_next_cur",      32'(cur_sel), 32'h1);
    repeat (4) @(negedge clk);

    // Busy: request held valid across a switch must wait for READY
    @(negedge clk);
    req_valid = 1'b1;
    req_sel   = 3'd2;
    @(posedge clk);
    @(negedge clk);
    req_sel    = 3'd0;
    ready_seen = 1'b0;
    n = 0;
    while (!done && n < BOUND) begin
      if (req_ready) ready_seen = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("busy_done",       32'(done),       32'h1);
    chk("busy_cur",        32'(cur_sel),    32'h2);
    chk("busy_ready_low",  32'(ready_seen), 32'h0);
    n = 0;
    while (!req_ready && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!done && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    chk("busy2_done", 32'(done),       32'h1);
    chk("busy2_cur",  32'(cur_sel),    32'h0);
    chk("busy2_sreq", 32'(select_req), 32'h1);
    repeat (4) @(negedge clk);

    // Reset asserted while in DROP
    @(negedge clk);
    req_valid = 1'b1;
    req_sel   = 3'd3;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rd_in_drop", 32'(select_req), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("rd_sreq",  32'(select_req), 32'h1);
    chk("rd_cur",   32'(cur_sel),    32'h0);
    chk("rd_ready", 32'(req_ready),  32'h1);
    chk("rd_pulse", 32'({done, err}), 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    pulse = 1'b0;
    repeat (8) begin
      @(negedge clk);
      pulse = pulse | done | err;
    end
    chk("rd_no_pulse",   32'(pulse),      32'h0);
    chk("rd_sreq_after", 32'(select_req), 32'h1);
    chk("rd_ready_after", 32'(req_ready), 32'h1);

    do_req(3'd2, outcome, lat, tf1, sr1);
    chk("rd_recover_outcome", 32'(outcome), 32'h2);
    chk("rd_recover_cur",     32'(cur_sel), 32'h2);
    repeat (3) @(negedge clk);

    chk("monitor_violations", 32'(viol), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clock_select_controller.md
CLOCK_SELECT_CONTROLLER -- requirements
Module: AhaClockSelectController

Interface
REQ-001 The block SHALL have parameter NUM_CLKS, default 4, meaning the number of clock sources and switch slices managed (2..8).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning the flop depth of each SELECT_ACK synchronizer (>=2).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1023, meaning the maximum CLK cycles spent in a wait state before a timeout.
REQ-004 The block SHALL have parameter RESET_SEL, default 0, meaning the clock index requested after reset.
REQ-005 CLK  input  1  free-running reference clock; all state is clocked on its rising edge.
REQ-006 RESETn  input  1  asynchronous, active-low reset.
REQ-007 REQ_VALID  input  1  new clock-select request valid.
REQ-008 REQ_SEL  input  3  requested clock index.
REQ-009 REQ_READY  output  1  controller accepts a request this cycle.
REQ-010 SELECT_REQ  output  NUM_CLKS  one-hot select request, one bit per switch slice.
REQ-011 SELECT_ACK  input  NUM_CLKS  per-slice acknowledge; asynchronous to CLK.
REQ-012 CUR_SEL  output  3  index of the currently granted clock.
REQ-013 DONE  output  1  one-cycle pulse: request completed.
REQ-014 ERR  output  1  one-cycle pulse: request rejected or timed out.
REQ-015 TIMEOUT_FLAG  output  1  sticky: the last switch timed out.

Function
REQ-016 Each SELECT_ACK bit SHALL pass through a SYNC_STAGES-deep synchronizer before use, giving ack_s.
REQ-017 The FSM SHALL have states IDLE, DROP, RAISE and FINISH.
REQ-018 REQ_READY SHALL be high only in IDLE; a request is accepted when REQ_VALID and REQ_READY are both high.
REQ-019 On an accepted request with REQ_SEL >= NUM_CLKS, the block SHALL pulse ERR in the next cycle, stay in IDLE, and leave all outputs otherwise unchanged.
REQ-020 On an accepted request with REQ_SEL == CUR_SEL, the block SHALL pulse DONE in the next cycle and stay in IDLE.
REQ-021 On any other accepted request, the block SHALL latch the target, clear SELECT_REQ to all zero in the next cycle, clear TIMEOUT_FLAG, and enter DROP.
REQ-022 In DROP, when ack_s is all zero, the block SHALL set SELECT_REQ to one-hot(target) and enter RAISE.
REQ-023 In RAISE, when ack_s equals one-hot(target), the block SHALL set CUR_SEL to the target and enter FINISH.
REQ-024 FINISH SHALL last one cycle, pulse DONE, and return to IDLE, so DONE is never asserted while the state is DROP or RAISE.
REQ-025 A wait counter SHALL clear on entry to DROP and to RAISE, and increment each cycle spent in those states.
REQ-026 On the cycle the wait counter reaches TIMEOUT_CYCLES in DROP or RAISE, the block SHALL:
- pulse ERR;
- set TIMEOUT_FLAG;
- return to IDLE with SELECT_REQ held and CUR_SEL unchanged.
REQ-027 If the wait condition and the timeout occur in the same cycle, the wait condition SHALL take priority and no timeout is reported.
REQ-028 At most one SELECT_REQ bit SHALL be high in any cycle.
REQ-029 SELECT_REQ SHALL be all zero for at least one full cycle between deasserting one bit and asserting another.
REQ-030 DONE and ERR SHALL never be asserted in the same cycle.
REQ-031 REQ_SEL and REQ_VALID SHALL be ignored outside IDLE.

Reset
REQ-032 While RESETn is low, the block SHALL hold:
- state = IDLE;
- SELECT_REQ = one-hot(RESET_SEL);
- CUR_SEL = RESET_SEL;
- REQ_READY = 1;
- DONE, ERR and TIMEOUT_FLAG = 0;
- wait counter and all synchronizer flops = 0.
REQ-033 Reset asserted mid-switch SHALL abort the switch immediately and restore the REQ-032 values, with no DONE or ERR pulse.

Verification
REQ-034 Nominal switch: slice model acks after 3 slice-clock edges, REQ_SEL = 2 from CUR_SEL = 0 -> SELECT_REQ goes 0001 to 0000 to 0100, CUR_SEL = 2, a single DONE pulse, no overlap of SELECT_REQ bits.
REQ-035 Same-index request: REQ_SEL = 0 while CUR_SEL = 0 -> DONE pulses the next cycle and SELECT_REQ stays 0001 throughout.
REQ-036 Out-of-range request: REQ_SEL = 5 with NUM_CLKS = 4 -> ERR pulses the next cycle and all other outputs are unchanged.
REQ-037 Raise timeout: TIMEOUT_CYCLES = 15, target slice never acks -> ERR pulses after 15 cycles in RAISE, TIMEOUT_FLAG = 1, CUR_SEL unchanged; the next accepted request clears TIMEOUT_FLAG.
REQ-038 Reset during DROP: RESETn pulsed low -> SELECT_REQ = 0001, CUR_SEL = 0, state IDLE, no DONE or ERR pulse.
REQ-039 Busy: REQ_VALID held high during RAISE -> the request is not accepted until REQ_READY returns high.
